// File: rtl/camera_yuv_tx.sv
// camera_yuv_tx: RGB pair to YUV422 sensor emulator (pclk/reset in; enable, in_valid/in_ready, in_rgb pairs; href, vsync, cam_data, frame_start, underrun out)
module camera_yuv_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r1,
  input  logic [7:0] in_g1,
  input  logic [7:0] in_b1,
  input  logic [7:0] in_r2,
  input  logic [7:0] in_g2,
  input  logic [7:0] in_b2,
  output logic       href,
  output logic       vsync,
  output logic [7:0] cam_data,
  output logic       frame_start,
  output logic       underrun
);
  localparam int L  = 2*H_ACTIVE + H_BLANK;
  localparam int HW = $clog2(L);
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  state_t st, nxt_st, after_last;
  logic [HW-1:0] h_cnt;
  logic [15:0] v_cnt, lines;
  logic wrap, last_line, act_c, rdy_c, fs_c;
  logic [7:0] y1, u, y2, v, y1_c, u_c, y2_c, v_c, byte_c;
  int ra, ga, ba;
  function automatic logic [7:0] sat(input int x);
    return x < 0 ? 8'd0 : x > 255 ? 8'd255 : x[7:0];
  endfunction
  function automatic logic [7:0] luma(input logic [7:0] r, g, b);
    return sat(16 + ((66*int'(r) + 129*int'(g) + 25*int'(b) + 128) >>> 8));
  endfunction
  function automatic int avg(input logic [7:0] a, b);
    return (int'(a) + int'(b) + 1) >>> 1;
  endfunction
  always_comb begin
    wrap       = h_cnt == HW'(L-1);
    lines      = st == VSYNC ? 16'(VSYNC_LINES) : st == VBACK ? 16'(VBP_LINES) :
                 st == ACTIVE ? 16'(V_ACTIVE) : 16'(VFP_LINES);
    last_line  = v_cnt == lines - 16'd1;
    after_last = st == VSYNC ? (VBP_LINES > 0 ? VBACK : ACTIVE) : st == VBACK ? ACTIVE :
                 (st == ACTIVE && VFP_LINES > 0) ? VFRONT : enable ? VSYNC : IDLE;
    nxt_st     = st == IDLE ? (enable ? VSYNC : IDLE) : last_line ? after_last : st;
    act_c      = st == ACTIVE && h_cnt < HW'(2*H_ACTIVE);
    rdy_c      = (act_c && h_cnt[1:0] == 2'd2 && h_cnt < HW'(2*H_ACTIVE-4)) ||
                 (h_cnt == HW'(L-2) && nxt_st == ACTIVE);
    fs_c       = st == VSYNC && v_cnt == 16'd0 && h_cnt == '0;
    byte_c     = h_cnt[1:0] == 2'd0 ? y1 : h_cnt[1:0] == 2'd1 ? u : h_cnt[1:0] == 2'd2 ? y2 : v;
    ra         = avg(in_r1, in_r2);
    ga         = avg(in_g1, in_g2);
    ba         = avg(in_b1, in_b2);
    y1_c       = luma(in_r1, in_g1, in_b1);
    y2_c       = luma(in_r2, in_g2, in_b2);
    u_c        = sat(128 + ((-38*ra - 74*ga + 112*ba + 128) >>> 8));
    v_c        = sat(128 + ((112*ra - 94*ga - 18*ba + 128) >>> 8));
  end
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      st          <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      href        <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      in_ready    <= 1'b0;
      underrun    <= 1'b0;
      cam_data    <= 8'd0;
      {y1, u, y2, v} <= {8'd16, 8'd128, 8'd16, 8'd128};
    end else begin
      h_cnt <= wrap ? '0 : h_cnt + 1'b1;
      if (wrap) begin
        st    <= nxt_st;
        v_cnt <= (last_line || st == IDLE) ? 16'd0 : v_cnt + 16'd1;
      end
      href        <= act_c;
      vsync       <= st == VSYNC;
      frame_start <= fs_c;
      in_ready    <= rdy_c;
      cam_data    <= act_c ? byte_c : 8'd0;
      underrun    <= fs_c ? 1'b0 : (in_ready && !in_valid) ? 1'b1 : underrun;
      if (in_ready)
        {y1, u, y2, v} <= in_valid ? {y1_c, u_c, y2_c, v_c} : {8'd16, 8'd128, 8'd16, 8'd128};
    end
endmodule
